// File: rtl/pooyan_rom_loader_if.sv
// Download bus between hps_io and the pooyan core: the ioctl byte stream
// coming in, and the re-registered dn_* write port going out to the core.
interface pooyan_rom_loader_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;

    // Download source (hps_io side / testbench)
    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr
    );

    // Loader
    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr
    );
endinterface

// File: rtl/pooyan_rom_loader.sv
// ROM download front-end for the pooyan core. Forwards in-range ioctl bytes
// to the core with one cycle of latency, tracks byte count and a 16-bit
// checksum, and keeps the core in reset until a complete image has arrived
// and a short hold-off has elapsed.
module pooyan_rom_loader #(
    parameter int ROM_BYTES   = 49152,
    parameter int HOLD_CYCLES = 255
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    pooyan_rom_loader_if.slave         io,
    output logic                       core_reset,
    output logic                       rom_ready,
    output logic                       rom_short,
    output logic                       rom_overflow,
    output logic [15:0]                rom_checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_READY,
        S_FAIL
    } state_t;

    localparam logic [24:0] ADDR_LIMIT = 25'(ROM_BYTES);
    localparam logic [16:0] FULL_COUNT = 17'(ROM_BYTES);
    localparam logic [7:0]  HOLD_INIT  = 8'(HOLD_CYCLES);

    state_t      state, state_nx;
    logic        dl_q;
    logic        rise, fall;
    logic        load_win;
    logic        in_range;
    logic        accepted;
    logic        oob;
    logic [16:0] byte_count;
    logic [7:0]  hold_cnt;

    // Edge detect on the download flag. dl_q resets high so a download that
    // is still asserted when reset releases is not mistaken for a new rise.
    assign rise = io.ioctl_download & ~dl_q;
    assign fall = ~io.ioctl_download & dl_q;

    // Strobes count only inside a load, including the strobe that arrives
    // together with the download rise (it belongs to the new load).
    assign load_win = (state == S_LOAD) | rise;
    assign in_range = io.ioctl_addr < ADDR_LIMIT;
    assign accepted = io.ioctl_wr & io.ioctl_download & load_win & in_range;
    assign oob      = io.ioctl_wr & io.ioctl_download & load_win & ~in_range;

    // Download flag delay register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) dl_q <= 1'b1;
        else       dl_q <= io.ioctl_download;
    end

    // State register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic: any new download rise restarts a load
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (rise) state_nx = S_LOAD;
            S_LOAD:  if (fall) state_nx = (byte_count == FULL_COUNT) ? S_HOLD : S_FAIL;
            S_HOLD: begin
                if (rise)               state_nx = S_LOAD;
                else if (hold_cnt <= 8'd1) state_nx = S_READY;
            end
            S_READY: if (rise) state_nx = S_LOAD;
            S_FAIL:  if (rise) state_nx = S_LOAD;
            default: state_nx = S_IDLE;
        endcase
    end

    // Hold-off counter: loaded when a complete image ends, counts down in HOLD
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            hold_cnt <= 8'd0;
        else if (state == S_LOAD && fall)
            hold_cnt <= HOLD_INIT;
        else if (state == S_HOLD && hold_cnt != 8'd0)
            hold_cnt <= hold_cnt - 8'd1;
    end

    // Byte count, checksum and status flags; all restart on a download rise
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            byte_count   <= 17'd0;
            rom_checksum <= 16'd0;
            rom_short    <= 1'b0;
            rom_overflow <= 1'b0;
        end else if (rise) begin
            byte_count   <= {16'd0, accepted};
            rom_checksum <= accepted ? {8'd0, io.ioctl_dout} : 16'd0;
            rom_short    <= 1'b0;
            rom_overflow <= oob;
        end else if (state == S_LOAD) begin
            if (accepted) begin
                if (byte_count != 17'h1FFFF) byte_count <= byte_count + 17'd1;
                rom_checksum <= rom_checksum + {8'd0, io.ioctl_dout};
            end
            if (oob) rom_overflow <= 1'b1;
            if (fall && byte_count != FULL_COUNT) rom_short <= 1'b1;
        end
    end

    // Core control outputs, registered from the next state so the core
    // leaves reset on the same edge that READY is entered
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            core_reset <= 1'b1;
            rom_ready  <= 1'b0;
        end else begin
            core_reset <= (state_nx != S_READY);
            rom_ready  <= (state_nx == S_READY);
        end
    end

    // Write path to the core: one cycle latency, address/data hold between strobes
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            io.dn_wr   <= 1'b0;
            io.dn_addr <= 16'd0;
            io.dn_data <= 8'd0;
        end else begin
            io.dn_wr <= accepted;
            if (accepted) begin
                io.dn_addr <= io.ioctl_addr[15:0];
                io.dn_data <= io.ioctl_dout;
            end
        end
    end

endmodule

// File: tb/tb_pooyan_rom_loader.sv
// Bench for pooyan_rom_loader. Uses a reduced image size so several full
// loads fit in a short run; the hold-off uses the full 255 cycles.
module tb_pooyan_rom_loader;

    localparam int ROM_BYTES = 1024;
    localparam int HOLD      = 255;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        core_reset, rom_ready, rom_short, rom_overflow;
    logic [15:0] rom_checksum;

    pooyan_rom_loader_if io ();

    pooyan_rom_loader #(.ROM_BYTES(ROM_BYTES), .HOLD_CYCLES(HOLD)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .io           (io.slave),
        .core_reset   (core_reset),
        .rom_ready    (rom_ready),
        .rom_short    (rom_short),
        .rom_overflow (rom_overflow),
        .rom_checksum (rom_checksum)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] model_sum;

    typedef struct {
        logic        dl;
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  dout;
        logic        e_wr;
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        logic [15:0] e_sum;
        logic        e_ovf;
        logic        e_short;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dn_wr"},   32'(io.dn_wr),      0);
        check({tag, "_dn_addr"}, 32'(io.dn_addr),    0);
        check({tag, "_dn_data"}, 32'(io.dn_data),    0);
        check({tag, "_core_rst"},32'(core_reset),    1);
        check({tag, "_ready"},   32'(rom_ready),     0);
        check({tag, "_short"},   32'(rom_short),     0);
        check({tag, "_ovf"},     32'(rom_overflow),  0);
        check({tag, "_sum"},     32'(rom_checksum),  0);
    endtask

    // Stream n bytes (data = addr[7:0]^key) back to back, then n_ovf writes
    // at 0xC000.. ; download is left high. Called at a negedge.
    task automatic send_image(input int n, input logic [7:0] key, input bit start_chk,
                              input int n_ovf);
        int         errs;
        logic [7:0] d;
        errs      = 0;
        model_sum = 16'd0;
        for (int i = 0; i < n; i++) begin
            d = 8'(i) ^ key;
            io.ioctl_download = 1'b1;
            io.ioctl_wr       = 1'b1;
            io.ioctl_addr     = 25'(i);
            io.ioctl_dout     = d;
            model_sum         = model_sum + {8'd0, d};
            @(negedge clk_sys);
            if (io.dn_wr !== 1'b1 || io.dn_addr !== 16'(i) || io.dn_data !== d) errs++;
            if (i == 0 && start_chk) begin
                check("start_core_reset", 32'(core_reset),   1);
                check("start_ready",      32'(rom_ready),    0);
                check("start_ovf_clear",  32'(rom_overflow), 0);
                check("start_sum",        32'(rom_checksum), 32'(key));
            end
        end
        for (int j = 0; j < n_ovf; j++) begin
            io.ioctl_wr   = 1'b1;
            io.ioctl_addr = 25'h00C000 + 25'(j);
            io.ioctl_dout = 8'hFF;
            @(negedge clk_sys);
            if (io.dn_wr !== 1'b0) errs++;
        end
        io.ioctl_wr = 1'b0;
        check("dn_stream", 32'(errs), 0);
    endtask

    // Drop download and measure cycles until core_reset falls.
    task automatic finish_ready();
        int k;
        k = 0;
        io.ioctl_download = 1'b0;
        @(posedge clk_sys);
        do begin
            @(posedge clk_sys);
            #1;
            k++;
        end while (core_reset && k < 400);
        check("hold_len", 32'(k), 32'(HOLD));
        check("ready",    32'(rom_ready), 1);
        @(negedge clk_sys);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        //             dl   wr    addr        dout   e_wr  e_addr    e_data e_sum     ovf   short
        vt[0] = '{1'b0, 1'b1, 25'h0000005, 8'h11, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 25'h0000003, 8'h22, 1'b1, 16'h0003, 8'h22, 16'h0022, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b0, 25'h0000007, 8'h33, 1'b0, 16'h0003, 8'h22, 16'h0022, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b1, 25'h00003FF, 8'h44, 1'b1, 16'h03FF, 8'h44, 16'h0066, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b1, 25'h0000400, 8'h55, 1'b0, 16'h03FF, 8'h44, 16'h0066, 1'b1, 1'b0};
        vt[5] = '{1'b1, 1'b1, 25'h0010005, 8'h66, 1'b0, 16'h03FF, 8'h44, 16'h0066, 1'b1, 1'b0};
        vt[6] = '{1'b1, 1'b1, 25'h0000000, 8'h77, 1'b1, 16'h0000, 8'h77, 16'h00DD, 1'b1, 1'b0};
        vt[7] = '{1'b0, 1'b1, 25'h0000001, 8'h88, 1'b0, 16'h0000, 8'h77, 16'h00DD, 1'b1, 1'b1};

        reset             = 1'b1;
        io.ioctl_download = 1'b0;
        io.ioctl_wr       = 1'b0;
        io.ioctl_addr     = 25'd0;
        io.ioctl_dout     = 8'd0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check_reset_values("rst");
        reset = 1'b0;

        // Write-path vectors: stray strobe, rise+strobe, boundary addresses, short end
        for (int i = 0; i < 8; i++) begin
            io.ioctl_download = vt[i].dl;
            io.ioctl_wr       = vt[i].wr;
            io.ioctl_addr     = vt[i].addr;
            io.ioctl_dout     = vt[i].dout;
            @(negedge clk_sys);
            check($sformatf("v%0d_dn_wr", i),   32'(io.dn_wr),     32'(vt[i].e_wr));
            check($sformatf("v%0d_dn_addr", i), 32'(io.dn_addr),   32'(vt[i].e_addr));
            check($sformatf("v%0d_dn_data", i), 32'(io.dn_data),   32'(vt[i].e_data));
            check($sformatf("v%0d_sum", i),     32'(rom_checksum), 32'(vt[i].e_sum));
            check($sformatf("v%0d_ovf", i),     32'(rom_overflow), 32'(vt[i].e_ovf));
            check($sformatf("v%0d_short", i),   32'(rom_short),    32'(vt[i].e_short));
        end
        io.ioctl_wr = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("v_fail_core_reset", 32'(core_reset), 1);
        check("v_fail_ready",      32'(rom_ready),  0);

        // Short load of 1000 bytes -> FAIL
        send_image(1000, 8'h00, 1'b1, 0);
        io.ioctl_download = 1'b0;
        repeat (5) @(negedge clk_sys);
        check("short_flag",       32'(rom_short),    1);
        check("short_core_reset", 32'(core_reset),   1);
        check("short_ready",      32'(rom_ready),    0);
        check("short_sum",        32'(rom_checksum), 32'(model_sum));

        // Full load -> HOLD -> READY
        send_image(ROM_BYTES, 8'h00, 1'b1, 0);
        finish_ready();
        check("full_sum",   32'(rom_checksum), 32'(model_sum));
        check("full_short", 32'(rom_short),    0);
        check("full_ovf",   32'(rom_overflow), 0);

        // Strobes with download low while running are ignored
        begin
            int errs;
            errs = 0;
            for (int i = 0; i < 5; i++) begin
                io.ioctl_wr   = 1'b1;
                io.ioctl_addr = 25'(i);
                io.ioctl_dout = 8'h99;
                @(negedge clk_sys);
                if (io.dn_wr !== 1'b0) errs++;
            end
            io.ioctl_wr = 1'b0;
            @(negedge clk_sys);
            check("idle_wr_dn",    32'(errs),         0);
            check("idle_wr_sum",   32'(rom_checksum), 32'(model_sum));
            check("idle_wr_ready", 32'(rom_ready),    1);
        end

        // Reload from READY with overflow writes
        send_image(ROM_BYTES, 8'h3C, 1'b1, 4);
        finish_ready();
        check("ovf_flag",  32'(rom_overflow), 1);
        check("ovf_short", 32'(rom_short),    0);
        check("ovf_sum",   32'(rom_checksum), 32'(model_sum));

        // Second reload: flags cleared at start, new checksum
        send_image(ROM_BYTES, 8'hA5, 1'b1, 0);
        finish_ready();
        check("reload_sum", 32'(rom_checksum), 32'(model_sum));
        check("reload_ovf", 32'(rom_overflow), 0);

        // Reset 100 bytes into a load, then a fresh full load
        send_image(100, 8'h00, 1'b0, 0);
        reset             = 1'b1;
        io.ioctl_download = 1'b0;
        @(negedge clk_sys);
        check_reset_values("midrst");
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        send_image(ROM_BYTES, 8'h5A, 1'b1, 0);
        finish_ready();
        check("after_rst_sum",   32'(rom_checksum), 32'(model_sum));
        check("after_rst_short", 32'(rom_short),    0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
